// File: rtl/sub_pkg.sv
// Shared types for the bit-serial borrow subtractor: FSM encoding and default width.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: difference and borrow-out for ai - bi - br.
module full_subtractor_bit (
  input  logic ai,
  input  logic bi,
  input  logic br,
  output logic di,
  output logic nb
);

  assign di = ai ^ bi ^ br;
  assign nb = (~ai & bi) | (~(ai ^ bi) & br);

endmodule

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial D = A - B, LSB first, one bit per clock through a single shared bit cell.
// Optional macro SUB_SIGNED_OVF_EN adds a two's-complement overflow output (ovf).
module serial_borrow_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] bvec,
  output logic             bout
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [WIDTH-1:0] bvec_q, bvec_d;
  logic             bout_q, bout_d;
  logic             cell_di, cell_nb;

  full_subtractor_bit u_bit (
    .ai (a_q[idx_q]),
    .bi (b_q[idx_q]),
    .br (borrow_q),
    .di (cell_di),
    .nb (cell_nb)
  );

`ifdef SUB_SIGNED_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    bvec_d   = bvec_q;
    bout_d   = bout_q;
`ifdef SUB_SIGNED_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = 1'b0;
          idx_d    = '0;
          diff_d   = '0;
          bvec_d   = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        diff_d[idx_q] = cell_di;
        bvec_d[idx_q] = cell_nb;
        borrow_d      = cell_nb;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          bout_d  = cell_nb;
`ifdef SUB_SIGNED_OVF_EN
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (cell_di != a_q[WIDTH-1]);
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      bvec_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      bvec_q   <= bvec_d;
      bout_q   <= bout_d;
`ifdef SUB_SIGNED_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign d    = diff_q;
  assign bvec = bvec_q;
  assign bout = bout_q;
`ifdef SUB_SIGNED_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Directed bench for serial_borrow_subtractor (WIDTH=4): latency, results, handshake, reset abort.
module tb_serial_borrow_subtractor;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, bout;
  logic [WIDTH-1:0] d, bvec;
`ifdef SUB_SIGNED_OVF_EN
  logic             ovf;
`endif

  int errors = 0;
  int checks = 0;

  serial_borrow_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bvec  (bvec),
    .bout  (bout)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for done (bounded), checks remaining latency, result and the one-cycle done pulse.
  task automatic wait_result(input string tag, input int exp_lat,
                             input logic [WIDTH-1:0] exp_d, input logic [WIDTH-1:0] exp_bvec,
                             input logic exp_bout, input logic exp_ovf);
    int cycles = 0;
    while (done !== 1'b1 && cycles < 12) begin
      tick();
      cycles++;
    end
    check({tag, ".lat"}, 32'(cycles), 32'(exp_lat));
    check({tag, ".busy"}, 32'(busy), 32'(1'b1));
    check({tag, ".d"}, 32'(d), 32'(exp_d));
    check({tag, ".bvec"}, 32'(bvec), 32'(exp_bvec));
    check({tag, ".bout"}, 32'(bout), 32'(exp_bout));
`ifdef SUB_SIGNED_OVF_EN
    check({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("unreachable");
`endif
    tick();
    check({tag, ".done_pulse"}, 32'(done), 32'(1'b0));
    check({tag, ".idle"}, 32'(busy), 32'(1'b0));
    check({tag, ".hold"}, 32'(d), 32'(exp_d));
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic [WIDTH-1:0] exp_d, input logic [WIDTH-1:0] exp_bvec,
                        input logic exp_bout, input logic exp_ovf);
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".accept"}, 32'(busy), 32'(1'b1));
    wait_result(tag, WIDTH, exp_d, exp_bvec, exp_bout, exp_ovf);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    check("rst.busy", 32'(busy), 32'(1'b0));
    check("rst.done", 32'(done), 32'(1'b0));
    check("rst.d", 32'(d), 32'(0));
    check("rst.bvec", 32'(bvec), 32'(0));
    check("rst.bout", 32'(bout), 32'(1'b0));
    rst = 1'b0;
    tick();

    run_op("9m3", 4'd9, 4'd3, 4'd6,  4'b0110, 1'b0, 1'b1);
    run_op("3m9", 4'd3, 4'd9, 4'd10, 4'b1000, 1'b1, 1'b1);

    // 0-1, then start held high through DONE: accepted on the first IDLE cycle.
    a = 4'd0;
    b = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    begin
      int cycles = 0;
      while (done !== 1'b1 && cycles < 12) begin
        tick();
        cycles++;
      end
      check("0m1.lat", 32'(cycles), 32'(WIDTH));
    end
    check("0m1.d", 32'(d), 32'(15));
    check("0m1.bvec", 32'(bvec), 32'(4'b1111));
    check("0m1.bout", 32'(bout), 32'(1'b1));
    a = 4'd5;
    b = 4'd5;
    start = 1'b1;
    tick();
    check("b2b.idle", 32'(busy), 32'(1'b0));
    check("b2b.hold_d", 32'(d), 32'(15));
    tick();
    check("b2b.accept", 32'(busy), 32'(1'b1));
    check("b2b.clr_d", 32'(d), 32'(0));
    check("b2b.clr_bvec", 32'(bvec), 32'(0));
    start = 1'b0;
    wait_result("5m5", WIDTH, 4'd0, 4'b0000, 1'b0, 1'b0);

    // start pulse during RUN is ignored and latched operands are unaffected.
    a = 4'd9;
    b = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 4'd1;
    b = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_result("ign", WIDTH - 2, 4'd6, 4'b0110, 1'b0, 1'b1);

    // Reset mid-RUN aborts; no done pulse follows.
    a = 4'd3;
    b = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.busy", 32'(busy), 32'(1'b0));
    check("abort.d", 32'(d), 32'(0));
    check("abort.bvec", 32'(bvec), 32'(0));
    check("abort.bout", 32'(bout), 32'(1'b0));
    begin
      int seen = 0;
      for (int i = 0; i < WIDTH + 3; i++) begin
        if (done === 1'b1) seen++;
        tick();
      end
      check("abort.no_done", 32'(seen), 32'(0));
    end

    // Signed-overflow vectors (d/bvec/bout checked in every build).
    run_op("8m1",  4'd8, 4'd1,  4'd7, 4'b0111, 1'b0, 1'b1);
    run_op("7m15", 4'd7, 4'd15, 4'd8, 4'b1000, 1'b1, 1'b1);
    run_op("6m2",  4'd6, 4'd2,  4'd4, 4'b0000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
